// File: rtl/cordic_pkg.sv
// Shared types and angle constants for the CORDIC range reducer.
// Constants are derived from a Q4.60 pi so any FRAC up to 60 rounds correctly.
package cordic_pkg;

  typedef enum logic [1:0] {StIdle, StWrap, StFold, StDone} state_e;

  // pi * 2^60, truncated; the next hex digit is 3, so rounding at FRAC <= 56 is exact.
  localparam logic [63:0] PiQ60 = 64'h3243_F6A8_885A_308D;

  // round(quarters * pi/2 * 2^frac); quarters in {1,2,3,4}.
  function automatic logic [63:0] angle_const(input int unsigned quarters,
                                              input int unsigned frac);
    logic [67:0] prod;
    prod = 68'(quarters) * {4'b0000, PiQ60};
    prod = prod + (68'd1 << (60 - frac));
    return 64'(prod >> (61 - frac));
  endfunction

endpackage

// File: rtl/cordic_range_reducer_if.sv
// Start/done handshake and result bus between a requester and the range reducer.
interface cordic_range_reducer_if #(
  parameter int unsigned W = 32
);
  logic         start;
  logic [W-1:0] angle_in;
  logic         operation_in;
  logic         ready;
  logic         done;
  logic [W-1:0] angle_out;
  logic [1:0]   shift_region_flag;
  logic         operation_out;

  modport master (
    output start, angle_in, operation_in,
    input  ready, done, angle_out, shift_region_flag, operation_out
  );

  modport slave (
    input  start, angle_in, operation_in,
    output ready, done, angle_out, shift_region_flag, operation_out
  );
endinterface

// File: rtl/cordic_range_reducer_quadrant_fold.sv
// Folds an angle in [0, 2pi) into [0, pi/2] and reports which results need negating.
module cordic_range_reducer_quadrant_fold
  import cordic_pkg::*;
#(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 28
) (
  input  logic [W-1:0] i_r,
  output logic [W-1:0] o_angle,
  output logic [1:0]   o_flag
);
  localparam logic [W-1:0] PI_2       = W'(angle_const(1, FRAC));
  localparam logic [W-1:0] PI         = W'(angle_const(2, FRAC));
  localparam logic [W-1:0] THREE_PI_2 = W'(angle_const(3, FRAC));
  localparam logic [W-1:0] TWO_PI     = W'(angle_const(4, FRAC));

  // i_r is non-negative here, so unsigned compares are safe; bit0 negates cos, bit1 sin.
  always_comb begin
    o_angle = i_r;
    o_flag  = 2'b00;
    if (i_r <= PI_2) begin
      o_angle = i_r;
      o_flag  = 2'b00;
    end else if (i_r <= PI) begin
      o_angle = PI - i_r;
      o_flag  = 2'b01;
    end else if (i_r < THREE_PI_2) begin
      o_angle = i_r - PI;
      o_flag  = 2'b11;
    end else begin
      o_angle = TWO_PI - i_r;
      o_flag  = 2'b10;
    end
  end

endmodule

// File: rtl/cordic_range_reducer.sv
// Wraps a signed angle into [0, 2pi), then folds it into the first quadrant.
// One angle in flight; done pulses 2+n edges after start, n = wrap corrections.
module cordic_range_reducer
  import cordic_pkg::*;
#(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 28
) (
  input logic                   clk,
  input logic                   rst,
  cordic_range_reducer_if.slave bus
);
  localparam logic signed [W-1:0] TWO_PI = W'(angle_const(4, FRAC));

  state_e              r_state, w_state_next;
  logic signed [W-1:0] r_acc;
  logic                r_op;
  logic [W-1:0]        r_angle_out;
  logic [1:0]          r_flag;
  logic                r_op_out;
  logic [W-1:0]        w_fold_angle;
  logic [1:0]          w_fold_flag;
  logic                w_acc_neg;
  logic                w_acc_big;

  assign w_acc_neg = r_acc[W-1];
  assign w_acc_big = r_acc >= TWO_PI;

  cordic_range_reducer_quadrant_fold #(
    .W    (W),
    .FRAC (FRAC)
  ) u_fold (
    .i_r     (r_acc),
    .o_angle (w_fold_angle),
    .o_flag  (w_fold_flag)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (bus.start) w_state_next = StWrap;
      StWrap: if (!w_acc_neg && !w_acc_big) w_state_next = StFold;
      StFold: w_state_next = StDone;
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_op        <= 1'b0;
      r_angle_out <= '0;
      r_flag      <= 2'b00;
      r_op_out    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_acc <= bus.angle_in;
            r_op  <= bus.operation_in;
          end
        end
        StWrap: begin
          if (w_acc_neg)      r_acc <= r_acc + TWO_PI;
          else if (w_acc_big) r_acc <= r_acc - TWO_PI;
        end
        StFold: begin
          r_angle_out <= w_fold_angle;
          r_flag      <= w_fold_flag;
          r_op_out    <= r_op;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready             = (r_state == StIdle);
  assign bus.done              = (r_state == StDone);
  assign bus.angle_out         = r_angle_out;
  assign bus.shift_region_flag = r_flag;
  assign bus.operation_out     = r_op_out;

endmodule

// File: tb/tb_cordic_range_reducer.sv
// Directed-vector bench for cordic_range_reducer with hand-computed Q4.28 results.
module tb_cordic_range_reducer;
  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  cordic_range_reducer_if #(.W(W)) tb_bus ();

  cordic_range_reducer #(
    .W    (W),
    .FRAC (28)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts one job, counts edges to done and checks the registered results.
  task automatic run_angle(input string tag, input logic [31:0] ang, input logic op,
                           input logic [31:0] exp_out, input logic [1:0] exp_flag,
                           input int exp_edges);
    int edges;
    bit seen;
    @(negedge clk);
    check_eq({tag, " ready"}, 64'(tb_bus.ready), 64'd1);
    tb_bus.start        = 1'b1;
    tb_bus.angle_in     = ang;
    tb_bus.operation_in = op;
    @(posedge clk);
    #1;
    tb_bus.start = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (tb_bus.done) seen = 1'b1;
    end
    check_eq({tag, " done_seen"}, 64'(seen), 64'd1);
    check_eq({tag, " latency"}, 64'(edges), 64'(exp_edges));
    check_eq({tag, " angle"}, 64'(tb_bus.angle_out), 64'(exp_out));
    check_eq({tag, " flag"}, 64'(tb_bus.shift_region_flag), 64'(exp_flag));
    check_eq({tag, " op"}, 64'(tb_bus.operation_out), 64'(op));
    @(posedge clk);
    #1;
    check_eq({tag, " done_pulse"}, 64'(tb_bus.done), 64'd0);
  endtask

  initial begin
    int  done_cnt;
    logic [31:0] cap_angle;
    logic [1:0]  cap_flag;
    n_checks            = 0;
    n_errors            = 0;
    rst                 = 1'b1;
    tb_bus.start        = 1'b0;
    tb_bus.angle_in     = '0;
    tb_bus.operation_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst ready", 64'(tb_bus.ready), 64'd1);
    check_eq("rst done", 64'(tb_bus.done), 64'd0);
    check_eq("rst angle", 64'(tb_bus.angle_out), 64'd0);
    check_eq("rst flag", 64'(tb_bus.shift_region_flag), 64'd0);
    check_eq("rst op", 64'(tb_bus.operation_out), 64'd0);

    run_angle("one",      32'h1000_0000, 1'b1, 32'h1000_0000, 2'b00, 2);
    run_angle("two",      32'h2000_0000, 1'b0, 32'h1243_F6A9, 2'b01, 2);
    run_angle("pi",       32'h3243_F6A9, 1'b1, 32'h0000_0000, 2'b01, 2);
    run_angle("pi_2",     32'h1921_FB54, 1'b0, 32'h1921_FB54, 2'b00, 2);
    run_angle("three_pi2",32'h4B65_F1FD, 1'b1, 32'h1921_FB54, 2'b10, 2);
    run_angle("neg_one",  32'hF000_0000, 1'b0, 32'h1000_0000, 2'b10, 3);
    run_angle("seven_9",  32'h7E66_6666, 1'b1, 32'h1865_7D94, 2'b01, 3);
    run_angle("neg_eight",32'h8000_0000, 1'b0, 32'h16CB_E3F9, 2'b11, 4);

    // Second start while busy must be ignored.
    @(negedge clk);
    tb_bus.start        = 1'b1;
    tb_bus.angle_in     = 32'h8000_0000;
    tb_bus.operation_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_bus.angle_in     = 32'h1000_0000;
    tb_bus.operation_in = 1'b0;
    @(posedge clk);
    #1;
    tb_bus.start = 1'b0;
    done_cnt  = 0;
    cap_angle = '0;
    cap_flag  = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (tb_bus.done) begin
        done_cnt++;
        cap_angle = tb_bus.angle_out;
        cap_flag  = tb_bus.shift_region_flag;
      end
    end
    check_eq("busy done_count", 64'(done_cnt), 64'd1);
    check_eq("busy angle", 64'(cap_angle), 64'h16CB_E3F9);
    check_eq("busy flag", 64'(cap_flag), 64'd3);
    check_eq("busy op", 64'(tb_bus.operation_out), 64'd1);

    // Reset while in WRAP aborts the job.
    @(negedge clk);
    tb_bus.start        = 1'b1;
    tb_bus.angle_in     = 32'hF000_0000;
    tb_bus.operation_in = 1'b1;
    @(posedge clk);
    #1;
    tb_bus.start = 1'b0;
    check_eq("abort in_wrap", 64'(tb_bus.ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort ready", 64'(tb_bus.ready), 64'd1);
    check_eq("abort angle", 64'(tb_bus.angle_out), 64'd0);
    check_eq("abort flag", 64'(tb_bus.shift_region_flag), 64'd0);
    check_eq("abort op", 64'(tb_bus.operation_out), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (tb_bus.done) done_cnt++;
    end
    check_eq("abort no_done", 64'(done_cnt), 64'd0);

    run_angle("fresh", 32'h1000_0000, 1'b1, 32'h1000_0000, 2'b00, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
